traffic_ctrl_nway: RTL

Parametrised N-approach traffic signal controller, the multi-way successor to the single-approach red/green/yellow sequencer. It cycles right-of-way round-robin across `N_WAYS` approaches with an all-red clearance interval between grants, and takes runtime-programmable phase durations. It also latches pedestrian requests per approach and supports a global enable that forces all-red. It sits between the intersection timing registers and the lamp-driver outputs.

---
 rtl/traffic_ctrl_nway.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl_nway.sv
// ============================================================================
//  Module   : traffic_ctrl_nway
//  Purpose  : Round-robin N-approach signal controller with all-red clearance,
//             programmable phase durations and optional pedestrian walk lamps
//             (optional feature macro: TRAFFIC_PED_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_ctrl_nway #(
    parameter int N_WAYS = 2,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [CNT_W-1:0]            green_cycles,
    input  logic [CNT_W-1:0]            yellow_cycles,
    input  logic [CNT_W-1:0]            allred_cycles,
    input  logic [N_WAYS-1:0]           ped_req,
    output logic [3*N_WAYS-1:0]         light,
    output logic [N_WAYS-1:0]           walk,
    output logic [$clog2(N_WAYS)-1:0]   active_way,
    output logic [1:0]                  phase,
    output logic                        phase_tick
);

    localparam int                 c_WAY_W    = $clog2(N_WAYS);
    localparam logic [c_WAY_W-1:0] c_LAST_WAY = c_WAY_W'(N_WAYS - 1);
    localparam logic [CNT_W-1:0]   c_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_ALLRED = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_timer;
    logic [c_WAY_W-1:0]  r_active_way;
    logic                r_phase_tick;

    logic [CNT_W-1:0]    w_green_eff;
    logic [CNT_W-1:0]    w_yellow_eff;
    logic [CNT_W-1:0]    w_allred_eff;
    logic [c_WAY_W-1:0]  w_way_next;
    logic                w_expire;

    // Zero-length durations are stretched to a single cycle.
    assign w_green_eff  = (green_cycles  == '0) ? c_ONE : green_cycles;
    assign w_yellow_eff = (yellow_cycles == '0) ? c_ONE : yellow_cycles;
    assign w_allred_eff = (allred_cycles == '0) ? c_ONE : allred_cycles;
    assign w_way_next   = (r_active_way == c_LAST_WAY) ? '0 : r_active_way + 1'b1;
    assign w_expire     = (r_timer <= c_ONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_ALLRED;
            r_timer      <= w_allred_eff;
            r_active_way <= '0;
            r_phase_tick <= 1'b0;
        end else if (!enable) begin
            // Forced all-red; an interrupted grant counts as served.
            r_state      <= S_ALLRED;
            r_timer      <= w_allred_eff;
            r_phase_tick <= (r_state != S_ALLRED);
            if (r_state == S_GREEN || r_state == S_YELLOW) begin
                r_active_way <= w_way_next;
            end
        end else begin
            r_phase_tick <= 1'b0;
            case (r_state)
                S_ALLRED: begin
                    if (w_expire) begin
                        r_state      <= S_GREEN;
                        r_timer      <= w_green_eff;
                        r_phase_tick <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_GREEN: begin
                    if (w_expire) begin
                        r_state      <= S_YELLOW;
                        r_timer      <= w_yellow_eff;
                        r_phase_tick <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (w_expire) begin
                        r_state      <= S_ALLRED;
                        r_timer      <= w_allred_eff;
                        r_active_way <= w_way_next;
                        r_phase_tick <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_ALLRED;
                    r_timer      <= w_allred_eff;
                    r_phase_tick <= 1'b1;
                end
            endcase
        end
    end

    assign active_way = r_active_way;
    assign phase      = r_state;
    assign phase_tick = r_phase_tick;

    for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_light
        assign light[3*gi +: 3] =
            (r_active_way != c_WAY_W'(gi)) ? 3'b100 :
            (r_state == S_GREEN)           ? 3'b001 :
            (r_state == S_YELLOW)          ? 3'b010 : 3'b100;
    end

`ifdef TRAFFIC_PED_EN
    logic [N_WAYS-1:0] r_ped_pend;
    logic [N_WAYS-1:0] r_walk;
    logic [N_WAYS-1:0] w_way_onehot;
    logic [N_WAYS-1:0] w_ped_clear;
    logic              w_enter_green;
    logic              w_hold_green;

    assign w_way_onehot  = N_WAYS'(1) << r_active_way;
    assign w_enter_green = enable && (r_state == S_ALLRED) && w_expire;
    assign w_hold_green  = enable && (r_state == S_GREEN) && !w_expire;
    // Clear is applied after the set so a same-edge request loses to the grant.
    assign w_ped_clear   = w_enter_green ? (w_way_onehot & r_ped_pend) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ped_pend <= '0;
            r_walk     <= '0;
        end else begin
            r_ped_pend <= (r_ped_pend | ped_req) & ~w_ped_clear;
            if (w_enter_green) begin
                r_walk <= r_ped_pend & w_way_onehot;
            end else if (!w_hold_green) begin
                r_walk <= '0;
            end
        end
    end

    assign walk = r_walk;
`else
    logic w_unused_ped;
    assign w_unused_ped = ^ped_req;
    assign walk         = '0;
`endif

endmodule

`default_nettype wire
